// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op encodings,
// sequencer states and the default datapath width.
package muldiv_pkg;

  localparam int DEFAULT_WIDTH = 32;

  // op input encodings; bit 0 selects divide, bit 1 selects signed
  localparam logic [1:0] OP_MULTU = 2'd0;
  localparam logic [1:0] OP_DIVU  = 2'd1;
  localparam logic [1:0] OP_MULT  = 2'd2;
  localparam logic [1:0] OP_DIV   = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/muldiv_iter.sv
// One iteration of the multi-cycle multiply/divide datapath.
// Multiply: acc = {partial product, remaining multiplier bits}; add the
// multiplicand when the current multiplier bit is set, then shift right.
// Divide:   acc = {partial remainder, remaining dividend / quotient bits};
// shift left, trial-subtract the divisor, shift the quotient bit in.
module muldiv_iter
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 div_i,
  input  logic [2*WIDTH-1:0]   acc_i,
  input  logic [WIDTH-1:0]     opnd_i,
  output logic [2*WIDTH-1:0]   acc_o
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] rem_new;
  logic             ge;

  // Both step variants are computed; div_i picks the one that is kept.
  always_comb begin
    sum     = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
    rem_sh  = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-1]};
    ge      = (rem_sh >= {1'b0, opnd_i});
    // Truncated subtraction is exact whenever ge holds with a non-zero divisor;
    // with a zero divisor it simply passes the shifted remainder through.
    diff    = rem_sh[WIDTH-1:0] - opnd_i;
    rem_new = ge ? diff : rem_sh[WIDTH-1:0];
    acc_o   = div_i ? {rem_new, acc_i[WIDTH-2:0], ge}
                    : {sum, acc_i[WIDTH-1:1]};
  end

endmodule

// File: rtl/muldiv_hilo_unit.sv
// Multi-cycle multiply/divide unit owning the HI/LO register pair.
// An accepted start runs WIDTH iterations of muldiv_iter, then commits the
// result to HI/LO and pulses done for one cycle; busy covers the iterations.
// Build option: define SIGNED_MULDIV_EN to make op 2/3 signed (magnitudes are
// taken at start, signs are fixed up on the commit edge). Without it, op[1]
// is ignored and every op is unsigned.
module muldiv_hilo_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               busy_q, done_q;
  logic [2*WIDTH-1:0] acc_q, acc_d, acc_step;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               div_q, div_d;
  logic               neg_pq_q, neg_pq_d;   // negate product / quotient at commit
  logic               neg_r_q, neg_r_d;     // negate remainder at commit

  logic               op_is_div, op_signed_req, signed_op;
  logic               x_neg, y_neg;
  logic [WIDTH-1:0]   x_mag, y_mag;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix, commit_hi, commit_lo;

  assign op_is_div     = (op == OP_DIVU) || (op == OP_DIV);
  assign op_signed_req = (op == OP_MULT) || (op == OP_DIV);

`ifdef SIGNED_MULDIV_EN
  assign signed_op = op_signed_req;
`else
  logic unused_signed_req;
  assign unused_signed_req = op_signed_req;
  assign signed_op         = 1'b0;
`endif

  assign x_neg = signed_op & x[WIDTH-1];
  assign y_neg = signed_op & y[WIDTH-1];
  assign x_mag = x_neg ? -x : x;
  assign y_mag = y_neg ? -y : y;

  muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .div_i  (div_q),
    .acc_i  (acc_q),
    .opnd_i (opnd_q),
    .acc_o  (acc_step)
  );

  // Sign fixup of the final iteration's result, applied on the commit edge.
  always_comb begin
    prod_fix  = neg_pq_q ? -acc_step : acc_step;
    quo_fix   = neg_pq_q ? -acc_step[WIDTH-1:0] : acc_step[WIDTH-1:0];
    rem_fix   = neg_r_q ? -acc_step[2*WIDTH-1:WIDTH] : acc_step[2*WIDTH-1:WIDTH];
    commit_hi = div_q ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
    commit_lo = div_q ? quo_fix : prod_fix[WIDTH-1:0];
  end

  // Next-state logic: iterate in RUN, accept work and MTHI/MTLO in IDLE/DONE.
  always_comb begin
    // NOTE: each _d defaults to its _q so no branch leaves a variable unassigned (no latch).
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    div_d    = div_q;
    neg_pq_d = neg_pq_q;
    neg_r_d  = neg_r_q;
    unique case (state_q)
      RUN: begin
        acc_d = acc_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = DONE;
          cnt_d   = '0;
          hi_d    = commit_hi;
          lo_d    = commit_lo;
        end
      end
      default: begin
        state_d = IDLE;
        if (mthi) hi_d = wdata;
        if (mtlo) lo_d = wdata;
        if (start) begin
          state_d  = RUN;
          cnt_d    = '0;
          acc_d    = {{WIDTH{1'b0}}, x_mag};
          opnd_d   = y_mag;
          div_d    = op_is_div;
          neg_pq_d = x_neg ^ y_neg;
          neg_r_d  = x_neg;
        end
      end
    endcase
  end

  // Sequencer, counter, HI/LO and registered status outputs.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= (state_d == RUN);
      done_q  <= (state_d == DONE);
    end
  end

  // Operand and accumulator registers.
  always_ff @(posedge clk) begin
    // NOTE: no reset here; these are always loaded on an accepted start before being used.
    acc_q    <= acc_d;
    opnd_q   <= opnd_d;
    div_q    <= div_d;
    neg_pq_q <= neg_pq_d;
    neg_r_q  <= neg_r_d;
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
